// File: rtl/multi_rate_limiter_if.sv
// Per-channel packet handshake between the packet sources and the rate limiter.
// Sources drive start/end strobes; the limiter reports which channels accept a start.
interface multi_rate_limiter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] pktStart;
    logic [NUM_CH-1:0] pktEnd;
    logic [NUM_CH-1:0] startReady;

    modport master (output pktStart, output pktEnd, input startReady);
    modport slave  (input pktStart, input pktEnd, output startReady);
endinterface

// File: rtl/multi_rate_limiter.sv
// Multi-channel packet rate limiter: enforces a minimum start-to-start slot per channel,
// classifies packet lengths and keeps saturating per-channel statistics.
module multi_rate_limiter #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int SLOT    = 50,
    parameter int MAX_LEN = 64,
    parameter int TIME_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_rate_limiter_if.slave       pkt_if,
    input  logic                      clrCnt,
    output logic [2*NUM_CH-1:0]       chState,
    output logic [NUM_CH*CNT_W-1:0]   startCnt,
    output logic [NUM_CH*CNT_W-1:0]   endCnt,
    output logic [NUM_CH*CNT_W-1:0]   validCnt,
    output logic [NUM_CH*CNT_W-1:0]   errCnt,
    output logic [NUM_CH*CNT_W-1:0]   dropCnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } ch_state_e;

    localparam logic [TIME_W-1:0] SLOT_M1 = TIME_W'(SLOT - 1);
    localparam logic [TIME_W-1:0] SLOT_M2 = TIME_W'(SLOT - 2);
    localparam logic [TIME_W-1:0] MAX_T   = TIME_W'(MAX_LEN);

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [TIME_W-1:0] pkt_time_q [NUM_CH];
    logic [TIME_W-1:0] pkt_time_d [NUM_CH];
    logic [TIME_W-1:0] delay_q [NUM_CH];
    logic [TIME_W-1:0] delay_d [NUM_CH];

    logic [CNT_W-1:0] start_cnt_q [NUM_CH];
    logic [CNT_W-1:0] start_cnt_d [NUM_CH];
    logic [CNT_W-1:0] end_cnt_q   [NUM_CH];
    logic [CNT_W-1:0] end_cnt_d   [NUM_CH];
    logic [CNT_W-1:0] valid_cnt_q [NUM_CH];
    logic [CNT_W-1:0] valid_cnt_d [NUM_CH];
    logic [CNT_W-1:0] err_cnt_q   [NUM_CH];
    logic [CNT_W-1:0] err_cnt_d   [NUM_CH];
    logic [CNT_W-1:0] drop_cnt_q  [NUM_CH];
    logic [CNT_W-1:0] drop_cnt_d  [NUM_CH];

    logic inc_start [NUM_CH];
    logic inc_end   [NUM_CH];
    logic inc_valid [NUM_CH];
    logic inc_err   [NUM_CH];
    logic inc_drop  [NUM_CH];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                              input logic en, input logic clr);
        if (clr)
            return '0;
        if (en && (v != '1))
            return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]    = state_q[c];
            pkt_time_d[c] = pkt_time_q[c];
            delay_d[c]    = delay_q[c];
            inc_start[c]  = 1'b0;
            inc_end[c]    = 1'b0;
            inc_valid[c]  = 1'b0;
            inc_err[c]    = 1'b0;
            inc_drop[c]   = 1'b0;

            case (state_q[c])
                IDLE: begin
                    if (pkt_if.pktStart[c]) begin
                        state_d[c]    = ACTIVE;
                        pkt_time_d[c] = TIME_W'(1);
                        inc_start[c]  = 1'b1;
                    end
                end
                ACTIVE: begin
                    inc_drop[c] = pkt_if.pktStart[c];
                    if (pkt_if.pktEnd[c]) begin
                        inc_end[c] = 1'b1;
                        if (pkt_time_q[c] < SLOT_M1) begin
                            inc_valid[c] = 1'b1;
                            delay_d[c]   = SLOT_M2 - pkt_time_q[c];
                            state_d[c]   = HOLD;
                        end else if (pkt_time_q[c] == SLOT_M1) begin
                            inc_valid[c] = 1'b1;
                            state_d[c]   = IDLE;
                        end else begin
                            inc_err[c] = 1'b1;
                            state_d[c] = IDLE;
                        end
                    end else if (pkt_time_q[c] == MAX_T) begin
                        inc_err[c] = 1'b1;
                        state_d[c] = IDLE;
                    end else begin
                        pkt_time_d[c] = pkt_time_q[c] + TIME_W'(1);
                    end
                end
                HOLD: begin
                    inc_drop[c] = pkt_if.pktStart[c];
                    if (delay_q[c] == '0)
                        state_d[c] = IDLE;
                    else
                        delay_d[c] = delay_q[c] - TIME_W'(1);
                end
                default: state_d[c] = IDLE;
            endcase

            start_cnt_d[c] = bump(start_cnt_q[c], inc_start[c], clrCnt);
            end_cnt_d[c]   = bump(end_cnt_q[c],   inc_end[c],   clrCnt);
            valid_cnt_d[c] = bump(valid_cnt_q[c], inc_valid[c], clrCnt);
            err_cnt_d[c]   = bump(err_cnt_q[c],   inc_err[c],   clrCnt);
            drop_cnt_d[c]  = bump(drop_cnt_q[c],  inc_drop[c],  clrCnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]     <= IDLE;
                pkt_time_q[c]  <= '0;
                delay_q[c]     <= '0;
                start_cnt_q[c] <= '0;
                end_cnt_q[c]   <= '0;
                valid_cnt_q[c] <= '0;
                err_cnt_q[c]   <= '0;
                drop_cnt_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]     <= state_d[c];
                pkt_time_q[c]  <= pkt_time_d[c];
                delay_q[c]     <= delay_d[c];
                start_cnt_q[c] <= start_cnt_d[c];
                end_cnt_q[c]   <= end_cnt_d[c];
                valid_cnt_q[c] <= valid_cnt_d[c];
                err_cnt_q[c]   <= err_cnt_d[c];
                drop_cnt_q[c]  <= drop_cnt_d[c];
            end
        end
    end

    // Outputs decode registered state only, so startReady has no path from the strobes.
    always_comb begin
        pkt_if.startReady = '0;
        chState           = '0;
        startCnt          = '0;
        endCnt            = '0;
        validCnt          = '0;
        errCnt            = '0;
        dropCnt           = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pkt_if.startReady[c]         = (state_q[c] == IDLE);
            chState[2*c +: 2]            = state_q[c];
            startCnt[c*CNT_W +: CNT_W]   = start_cnt_q[c];
            endCnt[c*CNT_W +: CNT_W]     = end_cnt_q[c];
            validCnt[c*CNT_W +: CNT_W]   = valid_cnt_q[c];
            errCnt[c*CNT_W +: CNT_W]     = err_cnt_q[c];
            dropCnt[c*CNT_W +: CNT_W]    = drop_cnt_q[c];
        end
    end

endmodule

// File: tb/tb_multi_rate_limiter.sv
// Directed bench for multi_rate_limiter: a default 4-channel instance plus a narrow
// 4-bit-counter instance used to exercise saturation.
module tb_multi_rate_limiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: defaults (SLOT=50, MAX_LEN=64, CNT_W=32)
    multi_rate_limiter_if #(.NUM_CH(4)) busA ();
    logic         clrA;
    logic [7:0]   chStateA;
    logic [127:0] startCntA, endCntA, validCntA, errCntA, dropCntA;

    multi_rate_limiter dutA (
        .clk      (clk),
        .rst      (rst),
        .pkt_if   (busA.slave),
        .clrCnt   (clrA),
        .chState  (chStateA),
        .startCnt (startCntA),
        .endCnt   (endCntA),
        .validCnt (validCntA),
        .errCnt   (errCntA),
        .dropCnt  (dropCntA)
    );

    // Narrow instance: 2 channels, 4-bit counters, SLOT=4
    multi_rate_limiter_if #(.NUM_CH(2)) busB ();
    logic       clrB;
    logic [3:0] chStateB;
    logic [7:0] startCntB, endCntB, validCntB, errCntB, dropCntB;

    multi_rate_limiter #(
        .NUM_CH(2), .CNT_W(4), .SLOT(4), .MAX_LEN(8), .TIME_W(4)
    ) dutB (
        .clk      (clk),
        .rst      (rst),
        .pkt_if   (busB.slave),
        .clrCnt   (clrB),
        .chState  (chStateB),
        .startCnt (startCntB),
        .endCnt   (endCntB),
        .validCnt (validCntB),
        .errCnt   (errCntB),
        .dropCnt  (dropCntB)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] chA(input logic [127:0] bus, input int ch);
        return bus[ch*32 +: 32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after each edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        busA.pktStart = '0;
        busA.pktEnd   = '0;
        busB.pktStart = '0;
        busB.pktEnd   = '0;
        clrA = 1'b0;
        clrB = 1'b0;

        #12;
        checkOutput("rst_ready", 64'(busA.startReady), 64'hF);
        checkOutput("rst_state", 64'(chStateA), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_startcnt", 64'(startCntA), 64'h0);

        // Channel 0: start at t, end at pktTime=10, HOLD until t+50
        busA.pktStart[0] = 1'b1;
        applyStimulus(1);
        busA.pktStart[0] = 1'b0;
        checkOutput("p1_active", 64'(chStateA[1:0]), 64'd1);
        checkOutput("p1_ready_lo", 64'(busA.startReady[0]), 64'd0);
        applyStimulus(9);
        busA.pktEnd[0] = 1'b1;
        applyStimulus(1);
        busA.pktEnd[0] = 1'b0;
        checkOutput("p1_hold", 64'(chStateA[1:0]), 64'd2);
        checkOutput("p1_start", 64'(chA(startCntA, 0)), 64'd1);
        checkOutput("p1_end", 64'(chA(endCntA, 0)), 64'd1);
        checkOutput("p1_valid", 64'(chA(validCntA, 0)), 64'd1);
        checkOutput("p1_err", 64'(chA(errCntA, 0)), 64'd0);
        applyStimulus(38);
        checkOutput("p1_hold_49", 64'(chStateA[1:0]), 64'd2);
        applyStimulus(1);
        checkOutput("p1_idle_50", 64'(chStateA[1:0]), 64'd0);
        checkOutput("p1_ready_50", 64'(busA.startReady[0]), 64'd1);

        // Second start at t+50, end exactly at pktTime=49: valid, straight to IDLE
        busA.pktStart[0] = 1'b1;
        applyStimulus(1);
        busA.pktStart[0] = 1'b0;
        checkOutput("p2_start", 64'(chA(startCntA, 0)), 64'd2);
        applyStimulus(48);
        busA.pktEnd[0] = 1'b1;
        applyStimulus(1);
        busA.pktEnd[0] = 1'b0;
        checkOutput("p2_idle_nohold", 64'(chStateA[1:0]), 64'd0);
        checkOutput("p2_valid", 64'(chA(validCntA, 0)), 64'd2);
        checkOutput("p2_end", 64'(chA(endCntA, 0)), 64'd2);

        // Overlong packet: end at pktTime=55
        busA.pktStart[0] = 1'b1;
        applyStimulus(1);
        busA.pktStart[0] = 1'b0;
        applyStimulus(54);
        checkOutput("p3_active_55", 64'(chStateA[1:0]), 64'd1);
        busA.pktEnd[0] = 1'b1;
        applyStimulus(1);
        busA.pktEnd[0] = 1'b0;
        checkOutput("p3_idle_56", 64'(chStateA[1:0]), 64'd0);
        checkOutput("p3_err", 64'(chA(errCntA, 0)), 64'd1);
        checkOutput("p3_end", 64'(chA(endCntA, 0)), 64'd3);
        checkOutput("p3_valid", 64'(chA(validCntA, 0)), 64'd2);

        // Timeout: no end, IDLE again at t+65; a late end changes nothing
        busA.pktStart[0] = 1'b1;
        applyStimulus(1);
        busA.pktStart[0] = 1'b0;
        applyStimulus(63);
        checkOutput("p4_ready_64", 64'(busA.startReady[0]), 64'd0);
        applyStimulus(1);
        checkOutput("p4_ready_65", 64'(busA.startReady[0]), 64'd1);
        checkOutput("p4_err", 64'(chA(errCntA, 0)), 64'd2);
        checkOutput("p4_end", 64'(chA(endCntA, 0)), 64'd3);
        applyStimulus(5);
        busA.pktEnd[0] = 1'b1;
        applyStimulus(1);
        busA.pktEnd[0] = 1'b0;
        checkOutput("p4_late_end", 64'(chA(endCntA, 0)), 64'd3);
        checkOutput("p4_late_valid", 64'(chA(validCntA, 0)), 64'd2);
        checkOutput("p4_late_state", 64'(chStateA[1:0]), 64'd0);

        // Clear wipes every channel's counters
        clrA = 1'b1;
        applyStimulus(1);
        clrA = 1'b0;
        checkOutput("clr_start0", 64'(chA(startCntA, 0)), 64'd0);
        checkOutput("clr_err0", 64'(chA(errCntA, 0)), 64'd0);

        // Channel 1: pktStart held, ends at pktTime=10; starts land at 0, 50, 100
        busA.pktStart[1] = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            busA.pktEnd[1] = ((c % 50) == 10);
            applyStimulus(1);
        end
        busA.pktStart[1] = 1'b0;
        busA.pktEnd[1]   = 1'b0;
        checkOutput("held_start", 64'(chA(startCntA, 1)), 64'd3);
        checkOutput("held_drop", 64'(chA(dropCntA, 1)), 64'd98);
        checkOutput("held_valid", 64'(chA(validCntA, 1)), 64'd2);
        checkOutput("held_ch0_iso", 64'(chA(startCntA, 0)), 64'd0);
        checkOutput("held_ch2_iso", 64'(chA(dropCntA, 2)), 64'd0);

        // Channel 3: clear coincident with a valid end, then a rejected start in HOLD
        busA.pktStart[3] = 1'b1;
        applyStimulus(1);
        busA.pktStart[3] = 1'b0;
        applyStimulus(9);
        busA.pktEnd[3] = 1'b1;
        clrA = 1'b1;
        applyStimulus(1);
        busA.pktEnd[3] = 1'b0;
        clrA = 1'b0;
        checkOutput("clrpri_valid", 64'(chA(validCntA, 3)), 64'd0);
        checkOutput("clrpri_end", 64'(chA(endCntA, 3)), 64'd0);
        checkOutput("clrpri_hold", 64'(chStateA[7:6]), 64'd2);
        busA.pktStart[3] = 1'b1;
        applyStimulus(1);
        busA.pktStart[3] = 1'b0;
        checkOutput("hold_drop", 64'(chA(dropCntA, 3)), 64'd1);
        checkOutput("hold_ready_lo", 64'(busA.startReady[3]), 64'd0);
        applyStimulus(3);

        // Asynchronous reset mid-HOLD takes effect before the next edge
        rst = 1'b1;
        #2;
        checkOutput("arst_state", 64'(chStateA), 64'h0);
        checkOutput("arst_ready", 64'(busA.startReady), 64'hF);
        checkOutput("arst_drop", 64'(dropCntA[127:64]), 64'h0);
        checkOutput("arst_start", 64'(startCntA[63:0]), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Narrow instance: start and end held on channel 0, one start every 4 cycles
        busB.pktStart[0] = 1'b1;
        busB.pktEnd[0]   = 1'b1;
        applyStimulus(21);
        checkOutput("sat_pre_start", 64'(startCntB[3:0]), 64'd6);
        checkOutput("sat_pre_valid", 64'(validCntB[3:0]), 64'd5);
        applyStimulus(79);
        busB.pktStart[0] = 1'b0;
        busB.pktEnd[0]   = 1'b0;
        checkOutput("sat_start", 64'(startCntB[3:0]), 64'd15);
        checkOutput("sat_end", 64'(endCntB[3:0]), 64'd15);
        checkOutput("sat_valid", 64'(validCntB[3:0]), 64'd15);
        checkOutput("sat_drop", 64'(dropCntB[3:0]), 64'd15);
        checkOutput("sat_err", 64'(errCntB[3:0]), 64'd0);
        checkOutput("sat_ch1_iso", 64'(startCntB[7:4]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
